// File: rtl/uart_alu_sequencer_pkg.sv
// Shared ALU definitions: default widths, opcode values and the opcode
// membership test used when the opcode byte of a frame arrives.
package uart_alu_sequencer_pkg;

  localparam int unsigned DEF_NB_DATA        = 8;
  localparam int unsigned DEF_NB_OP          = 6;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  localparam int unsigned OP_ADD = 32;
  localparam int unsigned OP_SUB = 34;
  localparam int unsigned OP_AND = 36;
  localparam int unsigned OP_OR  = 37;
  localparam int unsigned OP_XOR = 38;
  localparam int unsigned OP_SRA = 3;
  localparam int unsigned OP_SRL = 2;
  localparam int unsigned OP_NOR = 39;

  // True when the opcode field names one of the operations the ALU implements.
  function automatic logic is_known_op(input int unsigned op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundle between the sequencer, the UART RX/TX and the combinational ALU.
//
// Handshake: there is no back-pressure anywhere. rx_done, tx_done and
// tx_start are single-cycle strobes that qualify their data in the same
// cycle; a strobe the receiver is not waiting for is simply dropped.
// tx_data stays stable from the tx_start cycle until tx_done.
interface uart_alu_sequencer_if
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA = DEF_NB_DATA,
  parameter int unsigned NB_OP   = DEF_NB_OP
);
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] alu_data_a;
  logic [NB_DATA-1:0] alu_data_b;
  logic [NB_OP-1:0]   alu_op;
  logic               tx_done;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               op_error;
  logic               timeout;
  logic [2:0]         dbg_state;

  // Environment side: UART RX/TX and ALU.
  modport master (
    output rx_data, rx_done, alu_result, tx_done,
    input  alu_data_a, alu_data_b, alu_op, tx_data, tx_start, busy,
           op_error, timeout, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  rx_data, rx_done, alu_result, tx_done,
    output alu_data_a, alu_data_b, alu_op, tx_data, tx_start, busy,
           op_error, timeout, dbg_state
  );

endinterface

// File: rtl/uart_alu_sequencer_frame_timeout_counter.sv
// Idle-cycle counter between bytes of a frame. Expires when the count
// reaches TIMEOUT_CYCLES-1; the owner decides what expiry means.
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Clear wins over counting; the count parks at terminal until cleared.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != TERM)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clock) begin
    if (i_reset) count_q <= '0;
    else         count_q <= count_d;
  end

  assign o_expired = (count_q == TERM);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer: collects operand A, operand B and opcode bytes from the
// UART receiver, drives them onto the ALU, captures the result and hands it
// to the UART transmitter.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned NB_DATA        = DEF_NB_DATA,
  parameter int unsigned NB_OP          = DEF_NB_OP,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 i_clock,
  input logic                 i_reset,
  uart_alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               op_error_q, op_error_d;
  logic               timeout_q, timeout_d;

  logic in_wait;
  logic op_valid;
  logic to_clear;
  logic to_enable;
  logic to_expired;

  // Timeout only runs while a frame is partially received.
  assign in_wait   = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  assign to_clear  = !in_wait || bus.rx_done;
  assign to_enable = in_wait && !bus.rx_done;

  // Opcode byte must have all bits above the opcode field clear.
  assign op_valid = ((bus.rx_data >> NB_OP) == '0) &&
                    is_known_op(32'(bus.rx_data[NB_OP-1:0]));

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (to_clear),
    .i_enable (to_enable),
    .o_expired(to_expired)
  );

  // Next-state and datapath update; an arriving byte beats a same-cycle expiry.
  always_comb begin
    state_d    = state_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    result_d   = result_q;
    op_error_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_WAIT_A: begin
        if (bus.rx_done) begin
          data_a_d = bus.rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (bus.rx_done) begin
          data_b_d = bus.rx_data;
          state_d  = ST_WAIT_OP;
        end else if (to_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (bus.rx_done) begin
          if (op_valid) begin
            op_d    = bus.rx_data[NB_OP-1:0];
            state_d = ST_EXEC;
          end else begin
            op_error_d = 1'b1;
            state_d    = ST_WAIT_A;
          end
        end else if (to_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        result_d = bus.alu_result;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.tx_done) state_d = ST_WAIT_A;
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase
  end

  // State and datapath registers; reset overrides any frame in progress.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      result_q   <= '0;
      op_error_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      op_error_q <= op_error_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.alu_data_a = data_a_q;
  assign bus.alu_data_b = data_b_q;
  assign bus.alu_op     = op_q;
  assign bus.tx_data    = result_q;
  assign bus.tx_start   = (state_q == ST_SEND);
  assign bus.busy       = (state_q == ST_EXEC) || (state_q == ST_SEND) ||
                          (state_q == ST_WAIT_TX);
  assign bus.op_error   = op_error_q;
  assign bus.timeout    = timeout_q;
  assign bus.dbg_state  = state_q;

endmodule
